// File: rtl/piso_shift_tx_pkg.sv
// piso_pkg -- shared definitions for the piso_shift_tx serialiser.
//   state_t   : FSM state enumeration (IDLE, SHIFT, PARITY)
//   SOUT_IDLE : level driven on sout while no word is in flight
// PARITY is only entered when the PISO_PARITY_EN macro is defined.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic SOUT_IDLE = 1'b1;

endpackage

// File: rtl/piso_shift_tx_if.sv
// piso_shift_tx_if -- load handshake and serial output bundle.
//   bit_en      : shift strobe, consumes the current serial bit
//   load_valid  : parallel word offered
//   din         : parallel word, sampled only on accept
//   load_ready  : serialiser can accept a word
//   sout        : serial data (idle high)
//   sout_valid  : sout carries a data or parity bit
//   busy        : word in progress
//   done        : one-cycle pulse after the final bit is consumed
// Modports: master = producer/consumer side, slave = serialiser.
interface piso_shift_tx_if #(
  parameter int WIDTH = 8
);

  logic             bit_en;
  logic             load_valid;
  logic [WIDTH-1:0] din;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output bit_en, load_valid, din,
    input  load_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  bit_en, load_valid, din,
    output load_ready, sout, sout_valid, busy, done
  );

endinterface

// File: rtl/piso_shift_tx_bit_counter.sv
// piso_bit_counter -- modulo-MODULUS bit counter for the serialiser.
//   clk : clock, rising edge
//   rst : synchronous active-low reset, clears the count
//   clr : synchronous clear (new word accepted)
//   en  : advance by one
//   tc  : terminal count, high while count == MODULUS-1
// The count wraps to zero on an enabled terminal count, so it never
// exceeds MODULUS-1.
module piso_bit_counter #(
  parameter int MODULUS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(MODULUS + 1);

  logic [CW-1:0] count;

  assign tc = (count == CW'(MODULUS - 1));

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/piso_shift_tx.sv
// piso_shift_tx -- parallel-in / serial-out word transmitter.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-low reset
//   bus : piso_shift_tx_if.slave (load handshake + serial output)
// Parameters:
//   WIDTH     : data bits per word (2..32)
//   LSB_FIRST : 0 = MSB shifted first, 1 = LSB shifted first
// Optional feature: define PISO_PARITY_EN to append one even-parity bit
// after the data bits (WIDTH+1 bits per word).
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input logic              clk,
  input logic              rst,
  piso_shift_tx_if.slave   bus
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic             done_q;
  logic             accept;
  logic             consume;
  logic             final_consume;
  logic             tc;
  logic             head;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
`ifdef PISO_PARITY_EN
  logic             parity_q;
`endif

  assign accept  = bus.load_valid && (state == IDLE);
  assign consume = (state == SHIFT) && bus.bit_en;
  assign head    = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];

  piso_bit_counter #(
    .MODULUS (WIDTH)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (consume),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    final_consume = 1'b0;
    load_ready    = 1'b0;
    sout          = SOUT_IDLE;
    sout_valid    = 1'b0;
    busy          = 1'b0;
    unique case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (bus.load_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        sout       = head;
        sout_valid = 1'b1;
        busy       = 1'b1;
        if (bus.bit_en && tc) begin
`ifdef PISO_PARITY_EN
          state_next = PARITY;
`else
          state_next    = IDLE;
          final_consume = 1'b1;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        sout       = parity_q;
        sout_valid = 1'b1;
        busy       = 1'b1;
        if (bus.bit_en) begin
          state_next    = IDLE;
          final_consume = 1'b1;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Shift register and done pulse; the word only moves on a consumed
  // bit so sout holds while bit_en is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= final_consume;
      if (accept) begin
        shreg <= bus.din;
      end else if (consume) begin
        shreg <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
      end
    end
  end

`ifdef PISO_PARITY_EN
  // Parity is taken from the word as latched, before any shifting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^bus.din;
    end
  end
`endif

  assign bus.load_ready = load_ready;
  assign bus.sout       = sout;
  assign bus.sout_valid = sout_valid;
  assign bus.busy       = busy;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx -- self-checking bench for piso_shift_tx.
// Two instances (MSB-first and LSB-first, WIDTH=8) receive identical
// stimulus; expected serial bits come from a per-word reference model.
// Honours PISO_PARITY_EN when the design is built with it.
module tb_piso_shift_tx;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int NBITS = W + 1;
`else
  localparam int NBITS = W;
`endif

  logic         clk;
  logic         rst;
  logic         bit_en;
  logic         load_valid;
  logic [W-1:0] din;
  int           num_checks;
  int           num_failures;

  piso_shift_tx_if #(.WIDTH(W)) bus_a ();
  piso_shift_tx_if #(.WIDTH(W)) bus_b ();

  assign bus_a.bit_en     = bit_en;
  assign bus_a.load_valid = load_valid;
  assign bus_a.din        = din;
  assign bus_b.bit_en     = bit_en;
  assign bus_b.load_valid = load_valid;
  assign bus_b.din        = din;

  piso_shift_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  piso_shift_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: bit idx of a word as it should appear on the wire.
  function automatic logic model_bit(logic [W-1:0] w, int idx, bit lsb);
    if (idx >= W) return ^w;
    return lsb ? w[idx] : w[W-1-idx];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(string tag, logic [31:0] observed, logic [31:0] expected);
    num_checks++;
    assert (observed === expected) else begin
      num_failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_lanes(string tag, logic sa, logic sb, logic vld,
                             logic bsy, logic rdy, logic dn);
    check_output({tag, "_a_sout"},  32'(bus_a.sout),       32'(sa));
    check_output({tag, "_b_sout"},  32'(bus_b.sout),       32'(sb));
    check_output({tag, "_a_valid"}, 32'(bus_a.sout_valid), 32'(vld));
    check_output({tag, "_b_valid"}, 32'(bus_b.sout_valid), 32'(vld));
    check_output({tag, "_a_busy"},  32'(bus_a.busy),       32'(bsy));
    check_output({tag, "_b_busy"},  32'(bus_b.busy),       32'(bsy));
    check_output({tag, "_a_ready"}, 32'(bus_a.load_ready), 32'(rdy));
    check_output({tag, "_b_ready"}, 32'(bus_b.load_ready), 32'(rdy));
    check_output({tag, "_a_done"},  32'(bus_a.done),       32'(dn));
    check_output({tag, "_b_done"},  32'(bus_b.done),       32'(dn));
  endtask

  task automatic check_idle(string tag, logic dn);
    check_lanes(tag, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, dn);
  endtask

  // Send one word starting in a cycle where the DUT is idle; returns in
  // the done cycle. With hold set, load_valid stays high and din churns
  // during the word, so the caller must follow with another word.
  task automatic apply_stimulus(string tag, logic [W-1:0] w, int period, bit hold);
    check_output({tag, "_ready_in"}, 32'(bus_a.load_ready & bus_b.load_ready), 32'd1);
    load_valid = 1'b1;
    din        = w;
    bit_en     = 1'($urandom);
    step();
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < period; c++) begin
        load_valid = hold;
        if (hold) din = W'($urandom);
        bit_en = (c == period - 1);
        check_lanes($sformatf("%s_b%0d_c%0d", tag, b, c),
                    model_bit(w, b, 1'b0), model_bit(w, b, 1'b1),
                    1'b1, 1'b1, 1'b0, 1'b0);
        step();
      end
    end
    bit_en = 1'b0;
    check_idle({tag, "_done"}, 1'b1);
  endtask

  task automatic idle_cycle(string tag);
    load_valid = 1'b0;
    step();
    check_idle(tag, 1'b0);
  endtask

  initial begin
    logic [W-1:0] w;
    num_checks   = 0;
    num_failures = 0;
    rst        = 1'b0;
    bit_en     = 1'b0;
    load_valid = 1'b0;
    din        = '0;
    $display("[TB] start, NBITS=%0d", NBITS);

    // Reset holds the block idle even with a word offered.
    step();
    load_valid = 1'b1;
    bit_en     = 1'b1;
    din        = 8'hFF;
    step();
    check_idle("reset", 1'b0);
    rst        = 1'b1;
    load_valid = 1'b0;
    step();
    check_idle("post_reset", 1'b0);

    // Directed words.
    apply_stimulus("a5", 8'hA5, 1, 1'b0);
    idle_cycle("a5_gap");
    apply_stimulus("w01", 8'h01, 1, 1'b0);
    idle_cycle("w01_gap");
    apply_stimulus("w07", 8'h07, 1, 1'b0);
    idle_cycle("w07_gap");

    // Slow strobe: each bit held for four cycles.
    w = W'($urandom);
    apply_stimulus("slow4", w, 4, 1'b0);
    idle_cycle("slow4_gap");

    // load_valid held through a word, next word accepted in done cycle.
    w = W'($urandom);
    apply_stimulus("hold1", w, 1, 1'b1);
    w = W'($urandom);
    apply_stimulus("hold2", w, 2, 1'b0);
    idle_cycle("hold2_gap");

    // Randomised words.
    for (int i = 0; i < 6; i++) begin
      w = W'($urandom);
      apply_stimulus($sformatf("rnd%0d", i), w, int'($urandom_range(1, 3)), 1'b1);
    end
    w = W'($urandom);
    apply_stimulus("rnd_last", w, 1, 1'b0);
    idle_cycle("rnd_gap");

    // Reset during bit 3 aborts the word without a done pulse.
    w          = W'($urandom);
    load_valid = 1'b1;
    din        = w;
    step();
    load_valid = 1'b0;
    bit_en     = 1'b1;
    for (int b = 0; b < 3; b++) begin
      check_lanes($sformatf("abort_b%0d", b), model_bit(w, b, 1'b0),
                  model_bit(w, b, 1'b1), 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    check_lanes("abort_b3", model_bit(w, 3, 1'b0), model_bit(w, 3, 1'b1),
                1'b1, 1'b1, 1'b0, 1'b0);
    rst        = 1'b0;
    load_valid = 1'b1;
    step();
    rst        = 1'b1;
    load_valid = 1'b0;
    bit_en     = 1'b0;
    check_idle("abort_rst", 1'b0);
    step();
    check_idle("abort_after", 1'b0);

    // Recovery after the abort.
    w = W'($urandom);
    apply_stimulus("recover", w, 1, 1'b0);
    idle_cycle("recover_gap");

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
    $finish;
  end

endmodule
